// File: rtl/sd_dat_pkg.sv
// rtl/sd_dat_pkg.sv - shared states and constants for the SD DAT receive path
package sd_dat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        CRC,
        END_BIT,
        DONE
    } rx_state_e;

    localparam logic [3:0]  START_NIBBLE = 4'h0;
    localparam logic [3:0]  END_NIBBLE   = 4'hF;
    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam int          CRC_LEN      = 16;

endpackage

// File: rtl/sd_crc16_line.sv
// rtl/sd_crc16_line.sv - bit-serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT line
module sd_crc16_line
    import sd_dat_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        data,
    output logic [15:0] crc
);

    logic feedback;

    assign feedback = data ^ crc[15];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/dat_card_reader.sv
// rtl/dat_card_reader.sv - SD DAT card-to-host path: start detect, nibble deserialiser, FIFO push
// Optional per-line CRC16 check is compiled in with DAT_RX_CRC_CHECK_EN.
module dat_card_reader
    import sd_dat_pkg::*;
#(
    parameter int BLOCK_WORDS = 128,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        new_trans,
    input  logic [10:0] block_amount,
    input  logic [3:0]  card_in,
    output logic [31:0] buffer_out,
    output logic        fifo_enable_o,
    input  logic        fifo_ack_i,
    input  logic        fifo_full,
    output logic        card_ack_o,
    output logic        done,
    output logic        timeout_err,
    output logic        end_err,
    output logic        overrun_err,
    output logic        crc_err
);

    localparam int NIB_TOTAL = BLOCK_WORDS * 8;
    localparam int NW        = (NIB_TOTAL > 1) ? $clog2(NIB_TOTAL) : 1;
    localparam int WW        = $clog2(TIMEOUT + 1);
    localparam int CW        = $clog2(CRC_LEN);

    rx_state_e      state, next_state;
    logic [WW-1:0]  wait_cnt;
    logic [NW-1:0]  nib_cnt;
    logic [CW-1:0]  crc_cnt;
    logic [10:0]    block_cnt;
    logic [31:0]    shift;
    logic [31:0]    word;
    logic           pending;
    logic           accept;
    logic           start_trans;
    logic           start_seen;
    logic           wait_expire;
    logic           word_done;
    logic           block_end;

    assign word   = {shift[27:0], card_in};
    assign accept = fifo_enable_o & fifo_ack_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        start_trans = 1'b0;
        start_seen  = 1'b0;
        wait_expire = 1'b0;
        word_done   = 1'b0;
        block_end   = 1'b0;
        case (state)
            IDLE: begin
                if (new_trans) begin
                    start_trans = 1'b1;
                    next_state  = (block_amount == 11'd0) ? DONE : WAIT_START;
                end
            end
            WAIT_START: begin
                if (card_in == START_NIBBLE) begin
                    start_seen = 1'b1;
                    next_state = RECEIVE;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    wait_expire = 1'b1;
                    next_state  = DONE;
                end
            end
            RECEIVE: begin
                word_done = (nib_cnt[2:0] == 3'd7);
                if (nib_cnt == NW'(NIB_TOTAL - 1)) begin
                    next_state = CRC;
                end
            end
            CRC: begin
                if (crc_cnt == CW'(CRC_LEN - 1)) begin
                    next_state = END_BIT;
                end
            end
            END_BIT: begin
                block_end  = 1'b1;
                next_state = (block_cnt + 11'd1 == block_amount) ? DONE : WAIT_START;
            end
            DONE: begin
                // Hold here until new_trans drops so a level that stays high cannot restart.
                if (!new_trans) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            nib_cnt     <= '0;
            crc_cnt     <= '0;
            block_cnt   <= '0;
            shift       <= '0;
            card_ack_o  <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            end_err     <= 1'b0;
        end else begin
            wait_cnt   <= (state == WAIT_START) ? wait_cnt + WW'(1) : '0;
            crc_cnt    <= (state == CRC) ? crc_cnt + CW'(1) : '0;
            card_ack_o <= block_end;
            done       <= (next_state == DONE) && (state != DONE);
            if (start_seen) begin
                nib_cnt <= '0;
            end else if (state == RECEIVE) begin
                nib_cnt <= nib_cnt + NW'(1);
            end
            if (state == RECEIVE) begin
                shift <= word;
            end
            if (start_trans) begin
                block_cnt   <= '0;
                timeout_err <= 1'b0;
                end_err     <= 1'b0;
            end else begin
                if (block_end) begin
                    block_cnt <= block_cnt + 11'd1;
                end
                if (wait_expire) begin
                    timeout_err <= 1'b1;
                end
                if (block_end && (card_in != END_NIBBLE)) begin
                    end_err <= 1'b1;
                end
            end
        end
    end

    // Holding register doubles as buffer_out; request rises one cycle after the word lands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buffer_out    <= '0;
            pending       <= 1'b0;
            fifo_enable_o <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            if (word_done) begin
                buffer_out <= word;
            end
            pending       <= word_done | (pending & ~accept);
            fifo_enable_o <= pending & ~accept & ~fifo_full;
            if (start_trans) begin
                overrun_err <= 1'b0;
            end else if (word_done && pending && !accept) begin
                overrun_err <= 1'b1;
            end
        end
    end

`ifdef DAT_RX_CRC_CHECK_EN
    logic [15:0] crc_q [4];
    logic [3:0]  crc_exp;
    logic        crc_bad;

    for (genvar i = 0; i < 4; i++) begin : g_crc
        sd_crc16_line u_crc (
            .clock  (clock),
            .reset  (reset),
            .clear  (start_seen),
            .enable (state == RECEIVE),
            .data   (card_in[i]),
            .crc    (crc_q[i])
        );
        assign crc_exp[i] = crc_q[i][CW'(CRC_LEN - 1) - crc_cnt];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc_bad <= 1'b0;
            crc_err <= 1'b0;
        end else begin
            if (start_seen) begin
                crc_bad <= 1'b0;
            end else if ((state == CRC) && (card_in != crc_exp)) begin
                crc_bad <= 1'b1;
            end
            if (start_trans) begin
                crc_err <= 1'b0;
            end else if (block_end && crc_bad) begin
                crc_err <= 1'b1;
            end
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_dat_card_reader.sv
// tb/tb_dat_card_reader.sv - scoreboard bench for dat_card_reader (BLOCK_WORDS=2, TIMEOUT=16)
module tb_dat_card_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        new_trans = 1'b0;
    logic [10:0] block_amount = '0;
    logic [3:0]  card_in = 4'hF;
    logic [31:0] buffer_out;
    logic        fifo_enable_o;
    logic        fifo_ack_i = 1'b0;
    logic        fifo_full = 1'b0;
    logic        card_ack_o;
    logic        done;
    logic        timeout_err;
    logic        end_err;
    logic        overrun_err;
    logic        crc_err;

    int          vectors = 0;
    int          miscompares = 0;
    int          n_ack, n_done, n_en, n_en_full;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

`ifdef DAT_RX_CRC_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    always #5 clock = ~clock;

    dat_card_reader #(.BLOCK_WORDS(2), .TIMEOUT(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .new_trans     (new_trans),
        .block_amount  (block_amount),
        .card_in       (card_in),
        .buffer_out    (buffer_out),
        .fifo_enable_o (fifo_enable_o),
        .fifo_ack_i    (fifo_ack_i),
        .fifo_full     (fifo_full),
        .card_ack_o    (card_ack_o),
        .done          (done),
        .timeout_err   (timeout_err),
        .end_err       (end_err),
        .overrun_err   (overrun_err),
        .crc_err       (crc_err)
    );

    // One clock: drive a nibble, sample 1 time unit after the edge, act as the FIFO.
    task automatic tick(input logic [3:0] nib);
        card_in = nib;
        @(posedge clock);
        #1;
        if (fifo_enable_o && !fifo_ack_i) begin
            got_q.push_back(buffer_out);
            fifo_ack_i = 1'b1;
        end else begin
            fifo_ack_i = 1'b0;
        end
        if (card_ack_o) n_ack++;
        if (done) n_done++;
        if (fifo_enable_o) n_en++;
        if (fifo_enable_o && fifo_full) n_en_full++;
    endtask

    task automatic clear_counts;
        n_ack = 0; n_done = 0; n_en = 0; n_en_full = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    function automatic logic [3:0] data_nib(input logic [31:0] w0, input logic [31:0] w1, input int j);
        logic [31:0] w;
        w = (j < 8) ? w0 : w1;
        return w[(7 - (j % 8)) * 4 +: 4];
    endfunction

    function automatic logic [15:0] crc_line(input logic [31:0] w0, input logic [31:0] w1, input int line);
        logic [15:0] c;
        logic [3:0]  n;
        logic        fb;
        c = '0;
        for (int j = 0; j < 16; j++) begin
            n  = data_nib(w0, w1, j);
            fb = n[line] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [3:0] crc_nib(input logic [31:0] w0, input logic [31:0] w1, input int k,
                                           input bit corrupt);
        logic [3:0]  nib;
        logic [15:0] c;
        for (int i = 0; i < 4; i++) begin
            c      = crc_line(w0, w1, i);
            nib[i] = c[15 - k];
        end
        if (corrupt && k == 0) nib[2] = ~nib[2];
        return nib;
    endfunction

    task automatic start_transfer(input logic [10:0] n);
        block_amount = n;
        new_trans    = 1'b1;
        tick(4'hF);
        new_trans    = 1'b0;
    endtask

    task automatic send_block(input logic [31:0] w0, input logic [31:0] w1, input logic [3:0] end_nib,
                              input bit corrupt);
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        tick(4'h0);
        for (int j = 0; j < 16; j++) tick(data_nib(w0, w1, j));
        for (int k = 0; k < 16; k++) tick(crc_nib(w0, w1, k, corrupt));
        tick(end_nib);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #3 reset = 1'b0;
        #9;
        vectors++;
        if ({buffer_out, fifo_enable_o, card_ack_o, done} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, expected 0", {buffer_out, fifo_enable_o, card_ack_o, done});
        end
        vectors++;
        if ({timeout_err, end_err, overrun_err, crc_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_errors: got %b, expected 0000", {timeout_err, end_err, overrun_err, crc_err});
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) tick(4'hF);
    endtask

    task automatic test_single_block;
        clear_counts();
        start_transfer(11'd1);
        send_block(32'hCAFECAFE, 32'h0A0BF10A, 4'hF, 1'b0);
        repeat (6) tick(4'hF);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL single_count: got %0d words, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= got_q.size()) begin
                miscompares++;
                $display("FAIL single_word%0d: missing, expected %h", i, exp_q[i]);
            end else if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL single_word%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (n_ack != 1 || n_done != 1) begin
            miscompares++;
            $display("FAIL single_pulses: got ack=%0d done=%0d, expected 1 1", n_ack, n_done);
        end
        vectors++;
        if ({timeout_err, end_err, overrun_err, crc_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_errors: got %b, expected 0000", {timeout_err, end_err, overrun_err, crc_err});
        end
    endtask

    task automatic test_multi_block;
        clear_counts();
        start_transfer(11'd3);
        send_block(32'hFCB01AF0, 32'hABBA01FF, 4'hF, 1'b0);
        repeat (5) tick(4'hF);
        send_block(32'hAFA016F0, 32'h01AF001A, 4'hF, 1'b0);
        repeat (5) tick(4'hF);
        send_block(32'hABBACAFE, 32'hFF001ABA, 4'hF, 1'b0);
        repeat (6) tick(4'hF);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL multi_count: got %0d words, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= got_q.size()) begin
                miscompares++;
                $display("FAIL multi_word%0d: missing, expected %h", i, exp_q[i]);
            end else if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL multi_word%0d: got %h, expected %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (n_ack != 3 || n_done != 1) begin
            miscompares++;
            $display("FAIL multi_pulses: got ack=%0d done=%0d, expected 3 1", n_ack, n_done);
        end
    endtask

    task automatic test_zero_blocks;
        clear_counts();
        block_amount = 11'd0;
        new_trans    = 1'b1;
        repeat (4) tick(4'h0);
        new_trans    = 1'b0;
        repeat (4) tick(4'hF);
        vectors++;
        if (n_done != 1 || n_ack != 0 || n_en != 0) begin
            miscompares++;
            $display("FAIL zero_blocks: got done=%0d ack=%0d en=%0d, expected 1 0 0", n_done, n_ack, n_en);
        end
        vectors++;
        if ({timeout_err, end_err, overrun_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL zero_errors: got %b, expected 000", {timeout_err, end_err, overrun_err});
        end
    endtask

    task automatic test_fifo_full_overrun;
        logic [31:0] w0, w1;
        w0 = 32'h13579BDF;
        w1 = 32'h2468ACE0;
        clear_counts();
        exp_q.push_back(w1);
        start_transfer(11'd1);
        tick(4'h0);
        for (int j = 0; j < 16; j++) begin
            tick(data_nib(w0, w1, j));
            if (j == 7) fifo_full = 1'b1;
            if (j == 15) fifo_full = 1'b0;
        end
        for (int k = 0; k < 16; k++) tick(crc_nib(w0, w1, k, 1'b0));
        tick(4'hF);
        repeat (6) tick(4'hF);
        vectors++;
        if (n_en_full != 0) begin
            miscompares++;
            $display("FAIL full_enable: got %0d request cycles while full, expected 0", n_en_full);
        end
        vectors++;
        if (overrun_err !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_flag: got %b, expected 1", overrun_err);
        end
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++;
            $display("FAIL overrun_count: got %0d words, expected 1", got_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            miscompares++;
            $display("FAIL overrun_word: got %h, expected %h", got_q[0], exp_q[0]);
        end
    endtask

    task automatic test_timeout;
        int cnt;
        clear_counts();
        block_amount = 11'd1;
        new_trans    = 1'b1;
        tick(4'hF);
        cnt          = 1;
        new_trans    = 1'b0;
        while (!done && cnt < 40) begin
            tick(4'hF);
            cnt++;
        end
        vectors++;
        if (cnt != 17) begin
            miscompares++;
            $display("FAIL timeout_latency: got done at cycle %0d, expected 17", cnt);
        end
        vectors++;
        if (timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_flag: got %b, expected 1", timeout_err);
        end
        repeat (3) tick(4'hF);
        vectors++;
        if (n_en != 0 || n_done != 1) begin
            miscompares++;
            $display("FAIL timeout_quiet: got en=%0d done=%0d, expected 0 1", n_en, n_done);
        end
    endtask

    task automatic test_end_err;
        clear_counts();
        start_transfer(11'd1);
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sticky_clear: got timeout_err %b, expected 0", timeout_err);
        end
        send_block(32'h55AA33CC, 32'h0F1E2D3C, 4'h7, 1'b0);
        repeat (6) tick(4'hF);
        vectors++;
        if (end_err !== 1'b1) begin
            miscompares++;
            $display("FAIL end_flag: got %b, expected 1", end_err);
        end
        vectors++;
        if (n_done != 1 || n_ack != 1 || got_q.size() != 2) begin
            miscompares++;
            $display("FAIL end_complete: got done=%0d ack=%0d words=%0d, expected 1 1 2", n_done, n_ack,
                     got_q.size());
        end
    endtask

    task automatic test_crc;
        clear_counts();
        start_transfer(11'd1);
        send_block(32'hDEADBEEF, 32'h0BADF00D, 4'hF, 1'b1);
        repeat (6) tick(4'hF);
        vectors++;
        if (crc_err !== CRC_ON) begin
            miscompares++;
            $display("FAIL crc_flag: got %b, expected %b", crc_err, CRC_ON);
        end
        vectors++;
        if (end_err !== 1'b0 || n_done != 1) begin
            miscompares++;
            $display("FAIL crc_complete: got end_err=%b done=%0d, expected 0 1", end_err, n_done);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] w0, w1;
        w0 = 32'h12345678;
        w1 = 32'h9ABCDEF0;
        clear_counts();
        start_transfer(11'd1);
        tick(4'h0);
        for (int j = 0; j < 9; j++) tick(data_nib(w0, w1, j));
        vectors++;
        if (fifo_enable_o !== 1'b1 || buffer_out !== w0) begin
            miscompares++;
            $display("FAIL mid_pre: got en=%b word=%h, expected 1 %h", fifo_enable_o, buffer_out, w0);
        end
        #3 reset = 1'b0;
        fifo_ack_i = 1'b0;
        #1;
        vectors++;
        if ({buffer_out, fifo_enable_o, card_ack_o, done, timeout_err, end_err, overrun_err, crc_err} !== 39'd0)
        begin
            miscompares++;
            $display("FAIL mid_reset: got %h, expected 0",
                     {buffer_out, fifo_enable_o, card_ack_o, done, timeout_err, end_err, overrun_err, crc_err});
        end
        #1 reset = 1'b1;
        clear_counts();
        repeat (20) tick(4'hF);
        vectors++;
        if (n_en != 0 || got_q.size() != 0 || n_done != 0) begin
            miscompares++;
            $display("FAIL mid_after: got en=%0d words=%0d done=%0d, expected 0 0 0", n_en, got_q.size(), n_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_multi_block();
        test_zero_blocks();
        test_fifo_full_overrun();
        test_timeout();
        test_end_err();
        test_crc();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
